// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - fetch controller bus: program memory, decode handshake, redirect/halt
interface fetch_controller_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  en;
    logic [ADDR_WIDTH-1:0] pm_addr;
    logic [15:0]           pm_data;
    logic [15:0]           instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  halt_req;
    logic                  halted;
    logic [ADDR_WIDTH-1:0] pc;

    modport master (
        input  en, pm_data, instr_ready, redirect_valid, redirect_target, halt_req,
        output pm_addr, instr, instr_pc, instr_valid, halted, pc
    );

    modport slave (
        output en, pm_data, instr_ready, redirect_valid, redirect_target, halt_req,
        input  pm_addr, instr, instr_pc, instr_valid, halted, pc
    );
endinterface

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch sequencer with one-entry output register
module fetch_controller #(
    parameter int ADDR_WIDTH = 6,
    parameter bit WRAP_EN    = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_controller_if.master  bus
);
    typedef enum logic {RUN, HALT} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q;
    logic [15:0]           instr_q;
    logic                  instr_valid_q;
    logic                  halted_q;
    logic                  slot_free;
    logic                  capture;
    logic                  last_addr;

    assign pc_d      = pc_q + 1'b1;
    assign last_addr = (pc_q == {ADDR_WIDTH{1'b1}});
    assign slot_free = !instr_valid_q || bus.instr_ready;
    // A halt request in RUN takes the cycle, so it also blocks the capture.
    assign capture   = (state_q == RUN) && bus.en && slot_free &&
                       !bus.redirect_valid && !bus.halt_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= '0;
            instr_q       <= 16'hFFFF;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc_q          <= bus.redirect_target;
            instr_valid_q <= 1'b0;
            state_q       <= RUN;
            halted_q      <= 1'b0;
        end else if (capture) begin
            instr_q       <= bus.pm_data;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            pc_q          <= pc_d;
            if (!WRAP_EN && last_addr) begin
                state_q  <= HALT;
                halted_q <= 1'b1;
            end
        end else begin
            if (state_q == RUN && bus.halt_req) begin
                state_q  <= HALT;
                halted_q <= 1'b1;
            end
            if (bus.instr_ready && instr_valid_q) begin
                instr_valid_q <= 1'b0;
            end
        end
    end

    assign bus.pm_addr     = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed bench for fetch_controller, no-wrap and wrap instances
module tb_fetch_controller;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic rdy = 1'b0;
    logic rv = 1'b0;
    logic [AW-1:0] rt = '0;
    logic hr = 1'b0;
    logic [15:0] pm [64];

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    fetch_controller_if #(.ADDR_WIDTH(AW)) if0 ();
    fetch_controller_if #(.ADDR_WIDTH(AW)) if1 ();

    assign if0.en = en;
    assign if0.instr_ready = rdy;
    assign if0.redirect_valid = rv;
    assign if0.redirect_target = rt;
    assign if0.halt_req = hr;
    assign if0.pm_data = pm[if0.pm_addr];
    assign if1.en = en;
    assign if1.instr_ready = rdy;
    assign if1.redirect_valid = rv;
    assign if1.redirect_target = rt;
    assign if1.halt_req = hr;
    assign if1.pm_data = pm[if1.pm_addr];

    fetch_controller #(.ADDR_WIDTH(AW), .WRAP_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    fetch_controller #(.ADDR_WIDTH(AW), .WRAP_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input int a);
        check({tag, " valid"}, 32'(if0.instr_valid), 32'd1);
        check({tag, " instr_pc"}, 32'(if0.instr_pc), 32'(a));
        check({tag, " instr"}, 32'(if0.instr), 32'(pm[a]));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) pm[i] = 16'(i) * 16'h0101 ^ 16'h3C5A;
        pm[0] = 16'b10100_010_00000011;
        pm[7] = 16'hFFFF;

        // reset state
        #12;
        check("rst valid", 32'(if0.instr_valid), 32'd0);
        check("rst instr", 32'(if0.instr), 32'hFFFF);
        check("rst instr_pc", 32'(if0.instr_pc), 32'd0);
        check("rst pc", 32'(if0.pc), 32'd0);
        check("rst pm_addr", 32'(if0.pm_addr), 32'd0);
        check("rst halted", 32'(if0.halted), 32'd0);

        // free run
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        rdy = 1'b1;
        step();
        check("first instr", 32'(if0.instr), 32'hA203);
        check_word("free0", 0);
        check("free0 pc", 32'(if0.pc), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_word("free", i);
            check("free pm_addr", 32'(if0.pm_addr), 32'(i + 1));
        end

        // backpressure while instr_pc=4
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_word("bp hold", 4);
            check("bp pc", 32'(if0.pc), 32'd5);
        end
        rdy = 1'b1;
        for (int i = 5; i <= 22; i++) begin
            step();
            check_word("after bp", i);
        end

        // redirect to 24 while 22 is valid and accepted
        rv = 1'b1;
        rt = 6'd24;
        step();
        check("redir flush", 32'(if0.instr_valid), 32'd0);
        check("redir pc", 32'(if0.pc), 32'd24);
        rv = 1'b0;
        step();
        check_word("redir target", 24);

        // redirect and halt together: redirect wins
        rv = 1'b1;
        rt = 6'd40;
        hr = 1'b1;
        step();
        check("rh halted", 32'(if0.halted), 32'd0);
        check("rh pc", 32'(if0.pc), 32'd40);
        rv = 1'b0;
        hr = 1'b0;
        step();
        check_word("rh resume", 40);

        // halt with word 9 held under backpressure
        rv = 1'b1;
        rt = 6'd9;
        step();
        rv = 1'b0;
        step();
        check_word("pre halt", 9);
        check("pre halt pc", 32'(if0.pc), 32'd10);
        rdy = 1'b0;
        hr = 1'b1;
        step();
        check("halt halted", 32'(if0.halted), 32'd1);
        check_word("halt hold", 9);
        check("halt pc", 32'(if0.pc), 32'd10);
        hr = 1'b0;
        step();
        check_word("halt hold2", 9);
        rdy = 1'b1;
        step();
        check("halt drained", 32'(if0.instr_valid), 32'd0);
        check("halt pc2", 32'(if0.pc), 32'd10);
        step();
        check("halt idle valid", 32'(if0.instr_valid), 32'd0);
        check("halt idle pc", 32'(if0.pc), 32'd10);
        check("halt idle halted", 32'(if0.halted), 32'd1);
        rv = 1'b1;
        rt = 6'd30;
        step();
        check("unhalt halted", 32'(if0.halted), 32'd0);
        check("unhalt pc", 32'(if0.pc), 32'd30);
        rv = 1'b0;
        step();
        check_word("unhalt resume", 30);

        // en=0 drains and stops fetching
        en = 1'b0;
        step();
        check("en0 valid", 32'(if0.instr_valid), 32'd0);
        check("en0 pc", 32'(if0.pc), 32'd31);
        en = 1'b1;

        // end of memory
        rv = 1'b1;
        rt = 6'd61;
        step();
        rv = 1'b0;
        for (int i = 61; i <= 63; i++) begin
            step();
            check_word("eom", i);
        end
        check("eom0 halted", 32'(if0.halted), 32'd1);
        check("eom0 pc", 32'(if0.pc), 32'd0);
        check("eom1 halted", 32'(if1.halted), 32'd0);
        step();
        check("eom0 no wrap", 32'(if0.instr_valid), 32'd0);
        check("eom1 wrap valid", 32'(if1.instr_valid), 32'd1);
        check("eom1 wrap pc", 32'(if1.instr_pc), 32'd0);
        check("eom1 wrap instr", 32'(if1.instr), 32'hA203);
        step();
        check("eom0 still idle", 32'(if0.instr_valid), 32'd0);
        check("eom1 next pc", 32'(if1.instr_pc), 32'd1);

        // asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        check("async valid", 32'(if1.instr_valid), 32'd0);
        check("async pc", 32'(if1.pc), 32'd0);
        check("async halted", 32'(if0.halted), 32'd0);
        check("async instr", 32'(if1.instr), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
